// File: rtl/row_clear_engine_if.sv
// Placement handshake and status bundle for the row clear engine.
// The master side places pieces; the slave side (the engine) reports the grid.
interface row_clear_engine_if #(
  parameter int LINES_W = 8
);
  logic               place_valid;
  logic [11:0]        place_mask;
  logic               place_ready;
  logic [11:0]        grid;
  logic               busy;
  logic               collision;
  logic               done;
  logic [LINES_W-1:0] lines;

  modport master (
    output place_valid, place_mask,
    input  place_ready, grid, busy, collision, done, lines
  );

  modport slave (
    input  place_valid, place_mask,
    output place_ready, grid, busy, collision, done, lines
  );
endinterface

// File: rtl/row_clear_engine.sv
// Three-row by four-column grid: merges placed pieces and clears full rows one at a time,
// dropping the rows above each cleared row and counting cleared rows.
module row_clear_engine #(
  parameter int LINES_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  row_clear_engine_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    CLEAR,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [11:0]        grid_q;
  logic [11:0]        grid_next;
  logic [LINES_W-1:0] lines_q;
  logic [LINES_W-1:0] lines_next;
  logic [2:0]         row_sel;
  logic [2:0]         row_sel_next;
  logic               collision_q;
  logic               collision_next;

  logic full_top;
  logic full_mid;
  logic full_bot;

  assign full_top = &grid_q[3:0];
  assign full_mid = &grid_q[7:4];
  assign full_bot = &grid_q[11:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grid_q      <= 12'h000;
      lines_q     <= '0;
      row_sel     <= 3'b000;
      collision_q <= 1'b0;
    end else begin
      state       <= state_next;
      grid_q      <= grid_next;
      lines_q     <= lines_next;
      row_sel     <= row_sel_next;
      collision_q <= collision_next;
    end
  end

  always_comb begin
    state_next     = state;
    grid_next      = grid_q;
    lines_next     = lines_q;
    row_sel_next   = row_sel;
    collision_next = 1'b0;

    case (state)
      IDLE: begin
        if (bus.place_valid) begin
          if (|(grid_q & bus.place_mask)) begin
            collision_next = 1'b1;
          end else begin
            grid_next  = grid_q | bus.place_mask;
            state_next = CHECK;
          end
        end
      end

      // Only one row is cleared per visit; rows that become full after a
      // collapse are found on the next pass through CHECK.
      CHECK: begin
        if (full_top) begin
          row_sel_next = 3'b001;
          state_next   = CLEAR;
        end else if (full_mid) begin
          row_sel_next = 3'b010;
          state_next   = CLEAR;
        end else if (full_bot) begin
          row_sel_next = 3'b100;
          state_next   = CLEAR;
        end else begin
          state_next = DONE;
        end
      end

      CLEAR: begin
        case (row_sel)
          3'b001:  grid_next[3:0] = 4'h0;
          3'b010:  grid_next[7:0] = {grid_q[3:0], 4'h0};
          3'b100:  grid_next      = {grid_q[7:0], 4'h0};
          default: grid_next      = grid_q;
        endcase
        lines_next = lines_q + LINES_W'(1);
        state_next = CHECK;
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.place_ready = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.grid        = grid_q;
  assign bus.lines       = lines_q;
  assign bus.collision   = collision_q;

endmodule

// File: tb/tb_row_clear_engine.sv
// Self-checking bench for row_clear_engine: directed scenarios with literal expectations
// plus randomized placements compared every cycle against a gravity-style grid model.
module tb_row_clear_engine;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  row_clear_engine_if #(.LINES_W(8)) bus ();

  row_clear_engine #(.LINES_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] m_grid  = 12'h000;
  logic [7:0]  m_lines = 8'h00;
  int          m_rem   = 0;
  logic        m_coll  = 1'b0;

  logic        s_reset;
  logic        s_valid;
  logic [11:0] s_mask;
  logic [11:0] s_fin;
  int          s_k;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Repeatedly remove the topmost full row and let every row above it fall by one.
  function automatic void settle(input logic [11:0] g, output logic [11:0] fin, output int k);
    logic [3:0] r[3];
    bit         found;
    for (int i = 0; i < 3; i++) r[i] = g[4*i +: 4];
    k     = 0;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int i = 0; i < 3 && !found; i++) begin
        if (r[i] == 4'hF) begin
          found = 1'b1;
          for (int j = i; j > 0; j--) r[j] = r[j-1];
          r[0] = 4'h0;
          k++;
        end
      end
    end
    fin = {r[2], r[1], r[0]};
  endfunction

  // Model advances on each rising edge from the inputs present at that edge, then checks.
  always begin
    @(posedge clk);
    s_reset = reset;
    s_valid = bus.place_valid;
    s_mask  = bus.place_mask;
    if (s_reset) begin
      m_grid  = 12'h000;
      m_lines = 8'h00;
      m_rem   = 0;
      m_coll  = 1'b0;
    end else begin
      m_coll = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
      end else if (s_valid) begin
        if (|(m_grid & s_mask)) begin
          m_coll = 1'b1;
        end else begin
          settle(m_grid | s_mask, s_fin, s_k);
          m_grid  = s_fin;
          m_lines = m_lines + 8'(s_k);
          m_rem   = 2 * s_k + 2;
        end
      end
    end
    #1;
    check_output("ready", bus.place_ready, m_rem == 0);
    check_output("busy", bus.busy, m_rem != 0);
    check_output("done", bus.done, m_rem == 1);
    check_output("collision", bus.collision, m_coll);
    if (m_rem <= 1) begin
      check_output("grid", bus.grid, m_grid);
      check_output("lines", bus.lines, m_lines);
    end
  end

  task automatic apply_stimulus(input logic v, input logic [11:0] m, input logic r);
    @(negedge clk);
    bus.place_valid = v;
    bus.place_mask  = m;
    reset           = r;
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 12'hFFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset           = 1'b0;
    bus.place_valid = 1'b0;
    bus.place_mask  = 12'h000;
    check_output("rst_grid", bus.grid, 12'h000);
    check_output("rst_lines", bus.lines, 8'h00);
    check_output("rst_ready", bus.place_ready, 1'b1);
    check_output("rst_busy", bus.busy, 1'b0);
    check_output("rst_done", bus.done, 1'b0);
    check_output("rst_collision", bus.collision, 1'b0);
  endtask

  task automatic run_place(input logic [11:0] m, input int exp_lat, input logic [11:0] g_lit,
                           input logic [7:0] l_lit, input string name);
    int          lat;
    bit          seen;
    logic [11:0] g_at;
    logic [7:0]  l_at;
    apply_stimulus(1'b1, m, 1'b0);
    seen = 1'b0;
    lat  = -1;
    g_at = 12'hXXX;
    l_at = 8'hXX;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        lat  = i;
        g_at = bus.grid;
        l_at = bus.lines;
      end
      bus.place_valid = 1'b0;
      bus.place_mask  = 12'h000;
    end
    check_output({name, "_latency"}, lat, exp_lat);
    check_output({name, "_grid"}, g_at, g_lit);
    check_output({name, "_lines"}, l_at, l_lit);
    @(negedge clk);
  endtask

  initial begin
    int  lat;
    bit  seen;
    int  sel;
    bus.place_valid = 1'b1;
    bus.place_mask  = 12'hFFF;

    $display("[TB] reset with placement held active");
    do_reset();
    @(negedge clk);
    check_output("rst_no_done", bus.done, 1'b0);

    $display("[TB] single top-row clear");
    run_place(12'h00F, 4, 12'h000, 8'd1, "single");

    $display("[TB] collapse of middle row");
    do_reset();
    run_place(12'h312, 2, 12'h312, 8'd0, "place312");
    run_place(12'h0E0, 4, 12'h320, 8'd1, "collapse");
    check_output("model_pin_collapse", m_grid, 12'h320);

    $display("[TB] collision pulse");
    apply_stimulus(1'b1, 12'h020, 1'b0);
    @(negedge clk);
    bus.place_valid = 1'b0;
    check_output("coll_pulse", bus.collision, 1'b1);
    check_output("coll_grid", bus.grid, 12'h320);
    check_output("coll_busy", bus.busy, 1'b0);
    @(negedge clk);
    check_output("coll_end", bus.collision, 1'b0);
    check_output("coll_no_done", bus.done, 1'b0);

    $display("[TB] placements ignored while busy");
    apply_stimulus(1'b1, 12'h00F, 1'b0);
    @(negedge clk);
    bus.place_mask = 12'h0C0;
    seen = 1'b0;
    lat  = -1;
    for (int i = 2; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        lat  = i;
        bus.place_valid = 1'b0;
      end
    end
    check_output("busy_ign_latency", lat, 4);
    check_output("busy_ign_grid", bus.grid, 12'h320);
    check_output("busy_ign_lines", bus.lines, 8'd2);
    check_output("model_pin_lines", m_lines, 8'd2);
    @(negedge clk);
    check_output("busy_ign_idle_grid", bus.grid, 12'h320);

    $display("[TB] double clear");
    do_reset();
    run_place(12'hFF0, 6, 12'h000, 8'd2, "double");

    $display("[TB] reset during clear");
    do_reset();
    apply_stimulus(1'b1, 12'hFF0, 1'b0);
    @(negedge clk);
    bus.place_valid = 1'b0;
    bus.place_mask  = 12'h000;
    @(negedge clk);
    check_output("mid_clear_busy", bus.busy, 1'b1);
    check_output("mid_clear_grid", bus.grid, 12'hFF0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("mid_rst_grid", bus.grid, 12'h000);
    check_output("mid_rst_lines", bus.lines, 8'd0);
    check_output("mid_rst_ready", bus.place_ready, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check_output("mid_rst_no_done", seen, 1'b0);

    $display("[TB] lines counter wrap");
    do_reset();
    for (int i = 1; i <= 85; i++) begin
      run_place(12'hFFF, 8, 12'h000, 8'(3 * i), "triple");
    end
    check_output("wrap_at_255", bus.lines, 8'd255);
    run_place(12'h00F, 4, 12'h000, 8'd0, "wrap");

    $display("[TB] randomized placements");
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset           = ($urandom_range(0, 99) == 0);
      bus.place_valid = $urandom_range(0, 1) == 1;
      sel             = $urandom_range(0, 3);
      case (sel)
        0:       bus.place_mask = 12'($urandom);
        1:       bus.place_mask = (12'h00F << (4 * $urandom_range(0, 2))) | 12'($urandom_range(0, 3));
        2:       bus.place_mask = 12'h000;
        default: bus.place_mask = (~m_grid) & 12'($urandom);
      endcase
    end
    @(negedge clk);
    reset           = 1'b0;
    bus.place_valid = 1'b0;
    bus.place_mask  = 12'h000;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/row_clear_engine.md
ROW_CLEAR_ENGINE -- requirements
Module: row_clear_engine

Interface
REQ-001 SHALL have parameter LINES_W, default 8, width of the cleared-lines counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port place_valid  input  1  request to merge place_mask into the grid.
REQ-005 SHALL have port place_mask  input  12  piece cells: bits 3:0 top row, 7:4 middle row, 11:8 bottom row.
REQ-006 SHALL have port place_ready  output  1  high only in IDLE; placement accepted when place_valid & place_ready.
REQ-007 SHALL have port grid  output  12  registered grid occupancy, same bit layout as place_mask.
REQ-008 SHALL have port busy  output  1  high in CHECK, CLEAR, DONE.
REQ-009 SHALL have port collision  output  1  one-cycle pulse when a placement overlaps occupied cells.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a placement's clear sequence completes.
REQ-011 SHALL have port lines  output  LINES_W  total rows cleared since reset.

Function
REQ-012 SHALL implement FSM states IDLE, CHECK, CLEAR, DONE; place_ready = (state==IDLE), busy = !place_ready, done = (state==DONE).
REQ-013 IDLE: on place_valid with (grid & place_mask)!=0, SHALL leave grid unchanged, assert collision the next cycle for exactly one cycle, remain IDLE.
REQ-014 IDLE: on place_valid with no overlap, SHALL load grid <= grid | place_mask and go to CHECK; collision stays 0.
REQ-015 place_valid SHALL be ignored outside IDLE (no grid change, no collision).
REQ-016 CHECK: SHALL select one full row (all 4 bits 1) with fixed priority top > middle > bottom, latch it as a one-hot row select (001 top, 010 middle, 100 bottom) and go to CLEAR; if no row full, go to DONE.
REQ-017 CLEAR top: top <= 0; other rows unchanged.
REQ-018 CLEAR middle: middle <= old top, top <= 0; bottom unchanged.
REQ-019 CLEAR bottom: bottom <= old middle, middle <= old top, top <= 0.
REQ-020 CLEAR SHALL increment lines by 1 (modulo 2^LINES_W, wraps to 0) and return to CHECK.
REQ-021 DONE SHALL last exactly one cycle then go to IDLE.
REQ-022 Latency: placement with no full row SHALL reach DONE 2 cycles after acceptance edge; each full row cleared adds 2 cycles (CLEAR+CHECK).
REQ-023 A grid with multiple full rows SHALL be cleared one row per CLEAR visit, re-evaluated in CHECK after each collapse.
REQ-024 place_mask = 0 with place_valid SHALL be accepted (no collision) and run CHECK -> DONE.

Reset
REQ-025 reset SHALL take priority over all other inputs in every state, including mid-CLEAR.
REQ-026 On reset: state IDLE, grid 12'h000, lines 0, collision 0, done 0, busy 0, place_ready 1 on the following cycle.
REQ-027 A clear sequence interrupted by reset SHALL NOT complete; no done pulse, no lines increment.

Verification
REQ-028 Reset: assert reset 2 cycles with place_valid=1, mask 12'hFFF -> grid 000, lines 0, place_ready 1, no done.
REQ-029 Single clear: empty grid, place 12'h00F -> CHECK, CLEAR, CHECK, DONE; grid 000, lines 1, done high 4 cycles after acceptance.
REQ-030 Collapse: place 12'h312 (no clear, grid 312, done after 2 cycles), then place 12'h0E0 -> grid 3F2 -> middle cleared -> grid 320, lines 1.
REQ-031 Double clear: empty grid, place 12'hFF0 -> middle cleared first (grid F00), then bottom (grid 000); lines 2; done 6 cycles after acceptance.
REQ-032 Collision/busy: grid 320, place 12'h020 -> collision pulse 1 cycle, grid 320, no done; place_valid during busy -> ignored.
REQ-033 Reset mid-operation: assert reset during first CLEAR of REQ-031 -> grid 000, lines 0, IDLE next cycle, no done; lines wrap 255 -> 0 checked with LINES_W=8.
